// File: rtl/rv2t_write_back_if.sv
// Write-back stage bundle: ALU/load results in, register-file write port and
// decode hazard signals out.
interface rv2t_write_back_if #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned LD_BUF_DEPTH  = 2
);
    localparam int unsigned CNT_W = $clog2(LD_BUF_DEPTH + 1);

    logic                     alu_valid;
    logic [REG_ADDR_BITS-1:0] alu_rd;
    logic [XLEN-1:0]          alu_data;

    logic                     ld_valid;
    logic                     ld_ready;
    logic [REG_ADDR_BITS-1:0] ld_rd;
    logic [2:0]               ld_funct3;
    logic [1:0]               ld_addr_low;
    logic [XLEN-1:0]          ld_raw;

    logic [REG_ADDR_BITS-1:0] query_rs1;
    logic [REG_ADDR_BITS-1:0] query_rs2;
    logic                     stall_rs1;
    logic                     stall_rs2;

    logic                     wb_enable;
    logic [REG_ADDR_BITS-1:0] wb_addr;
    logic [XLEN-1:0]          wb_data;
    logic [CNT_W-1:0]         buf_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_funct3, ld_addr_low, ld_raw,
        output query_rs1, query_rs2,
        input  ld_ready, stall_rs1, stall_rs2,
        input  wb_enable, wb_addr, wb_data, buf_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_funct3, ld_addr_low, ld_raw,
        input  query_rs1, query_rs2,
        output ld_ready, stall_rs1, stall_rs2,
        output wb_enable, wb_addr, wb_data, buf_count
    );
endinterface

// File: rtl/rv2t_write_back.sv
// RV2T write-back: arbitrates ALU and formatted load results onto the single
// register-file write port, parking losing loads in a small ordered buffer.
module rv2t_write_back #(
    parameter int unsigned LD_BUF_DEPTH  = 2,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned REG_ADDR_BITS = 5
) (
    input logic            clk,
    input logic            reset,
    input logic            sync_reset,
    rv2t_write_back_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(LD_BUF_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(LD_BUF_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_BUF_DEPTH);

    typedef logic [REG_ADDR_BITS-1:0] rd_t;
    typedef logic [XLEN-1:0]          data_t;

    rd_t              buf_rd_q   [LD_BUF_DEPTH];
    rd_t              buf_rd_d   [LD_BUF_DEPTH];
    data_t            buf_data_q [LD_BUF_DEPTH];
    data_t            buf_data_d [LD_BUF_DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic  wb_en_q, wb_en_d;
    rd_t   wb_addr_q, wb_addr_d;
    data_t wb_data_q, wb_data_d;

    logic       alu_wr, ld_acc, ld_live, buf_empty, pop, push;
    logic       stall1, stall2;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    data_t      ld_fmt;

    assign bus.ld_ready  = (cnt_q < DEPTH_C);
    assign bus.wb_enable = wb_en_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.buf_count = cnt_q;
    assign bus.stall_rs1 = stall1;
    assign bus.stall_rs2 = stall2;

    always_comb begin
        ld_byte = bus.ld_raw[{bus.ld_addr_low, 3'b000} +: 8];
        ld_half = bus.ld_raw[{bus.ld_addr_low[1], 4'b0000} +: 16];
        case (bus.ld_funct3)
            3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = bus.ld_raw;
        endcase
    end

    // A load racing a same-rd ALU write is older and simply dies here.
    always_comb begin
        alu_wr    = bus.alu_valid && (bus.alu_rd != '0);
        ld_acc    = bus.ld_valid && bus.ld_ready;
        ld_live   = ld_acc && (bus.ld_rd != '0) &&
                    !(alu_wr && (bus.alu_rd == bus.ld_rd));
        buf_empty = (cnt_q == '0);
        pop       = !alu_wr && !buf_empty;
        push      = ld_live && (alu_wr || !buf_empty);

        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (alu_wr) begin
            wb_en_d   = 1'b1;
            wb_addr_d = bus.alu_rd;
            wb_data_d = bus.alu_data;
        end else if (pop) begin
            wb_en_d   = 1'b1;
            wb_addr_d = buf_rd_q[0];
            wb_data_d = buf_data_q[0];
        end else if (ld_live) begin
            wb_en_d   = 1'b1;
            wb_addr_d = bus.ld_rd;
            wb_data_d = ld_fmt;
        end
    end

    // Compact survivors toward entry 0 (oldest), then append the new load.
    always_comb begin
        logic [CNT_W-1:0] n;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        n          = '0;
        for (int unsigned i = 0; i < LD_BUF_DEPTH; i++) begin
            if ((CNT_W'(i) < cnt_q) && !(pop && (i == 0)) &&
                !(alu_wr && (buf_rd_q[i] == bus.alu_rd))) begin
                buf_rd_d[n[IDX_W-1:0]]   = buf_rd_q[i];
                buf_data_d[n[IDX_W-1:0]] = buf_data_q[i];
                n = n + CNT_W'(1);
            end
        end
        if (push) begin
            buf_rd_d[n[IDX_W-1:0]]   = bus.ld_rd;
            buf_data_d[n[IDX_W-1:0]] = ld_fmt;
            n = n + CNT_W'(1);
        end
        cnt_d = n;
    end

    always_comb begin
        stall1 = 1'b0;
        stall2 = 1'b0;
        for (int unsigned i = 0; i < LD_BUF_DEPTH; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                if ((bus.query_rs1 != '0) && (buf_rd_q[i] == bus.query_rs1)) stall1 = 1'b1;
                if ((bus.query_rs2 != '0) && (buf_rd_q[i] == bus.query_rs2)) stall2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            for (int unsigned i = 0; i < LD_BUF_DEPTH; i++) begin
                buf_rd_q[i]   <= '0;
                buf_data_q[i] <= '0;
            end
        end else if (sync_reset) begin
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            for (int unsigned i = 0; i < LD_BUF_DEPTH; i++) begin
                buf_rd_q[i]   <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            for (int unsigned i = 0; i < LD_BUF_DEPTH; i++) begin
                buf_rd_q[i]   <= buf_rd_d[i];
                buf_data_q[i] <= buf_data_d[i];
            end
        end
    end
endmodule

// File: tb/tb_rv2t_write_back.sv
// Bench for rv2t_write_back: directed scenarios plus random traffic checked
// against a queue-based model of the write-back rules.
module tb_rv2t_write_back;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    logic sync_reset;
    always #5 clk = ~clk;

    rv2t_write_back_if #(.XLEN(32), .REG_ADDR_BITS(5), .LD_BUF_DEPTH(DEPTH)) bus ();

    rv2t_write_back #(.LD_BUF_DEPTH(DEPTH), .XLEN(32), .REG_ADDR_BITS(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_acc;

    function automatic logic [31:0] fmt_load(logic [2:0] f3, logic [1:0] a, logic [31:0] raw);
        int unsigned b, h;
        b = (raw >> (8 * a)) & 32'hFF;
        h = (raw >> (a[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic m_stall(logic [4:0] q);
        if (q == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [39:0] wb_got();
        return {bus.wb_enable, bus.wb_addr, bus.wb_data, bus.buf_count};
    endfunction

    function automatic logic [39:0] wb_exp();
        return {m_en, m_addr, m_data, 2'(mq.size())};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_en = 0; m_addr = 0; m_data = 0; m_acc = 0;
    endtask

    task automatic model_clock();
        logic alu_w, keep;
        ent_t e;
        alu_w = bus.alu_valid && (bus.alu_rd != 0);
        m_acc = bus.ld_valid && (mq.size() < DEPTH);
        keep  = m_acc && (bus.ld_rd != 0) && !(alu_w && bus.alu_rd == bus.ld_rd);
        m_en  = 1'b1;
        if (alu_w) begin
            m_addr = bus.alu_rd;
            m_data = bus.alu_data;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].rd == bus.alu_rd) mq.delete(i);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_addr = e.rd;
            m_data = e.data;
        end else if (keep) begin
            m_addr = bus.ld_rd;
            m_data = fmt_load(bus.ld_funct3, bus.ld_addr_low, bus.ld_raw);
            keep = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (keep) begin
            e.rd   = bus.ld_rd;
            e.data = fmt_load(bus.ld_funct3, bus.ld_addr_low, bus.ld_raw);
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        if (reset || sync_reset) model_reset();
        else model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(logic v, logic [4:0] rd, logic [31:0] d);
        bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
    endtask

    task automatic drive_ld(logic v, logic [4:0] rd, logic [2:0] f3, logic [1:0] a, logic [31:0] raw);
        bus.ld_valid = v; bus.ld_rd = rd; bus.ld_funct3 = f3; bus.ld_addr_low = a; bus.ld_raw = raw;
    endtask

    task automatic idle();
        drive_alu(0, 0, 0);
        drive_ld(0, 0, 0, 0, 0);
        bus.query_rs1 = 0;
        bus.query_rs2 = 0;
    endtask

    task automatic test_reset();
        reset = 1; sync_reset = 0; idle();
        tick(); tick();
        reset = 0;
        #1;
        checks++;
        if (wb_got() !== 40'h0 || bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got wb/cnt=%h ready=%b, expected 0000000000 ready=1", wb_got(), bus.ld_ready);
        end
        drive_alu(1, 1, 32'h11); drive_ld(1, 9, 3'd2, 0, 32'h9999);
        tick();
        drive_alu(1, 2, 32'h22); drive_ld(1, 10, 3'd2, 0, 32'hAAAA);
        tick();
        checks++;
        if (bus.buf_count !== 2'd2 || wb_got() !== wb_exp()) begin
            errors++;
            $display("FAIL reset_prefill: got %h expected %h (cnt 2)", wb_got(), wb_exp());
        end
        idle();
        reset = 1;
        #1;
        checks++;
        if (bus.buf_count !== 2'd0 || bus.wb_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got cnt=%0d en=%b, expected cnt=0 en=0", bus.buf_count, bus.wb_enable);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (bus.buf_count !== 2'd0 || bus.wb_enable !== 1'b0 || bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got cnt=%0d en=%b ready=%b, expected 0 0 1", bus.buf_count, bus.wb_enable, bus.ld_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.wb_enable !== 1'b0 || wb_got() !== wb_exp()) begin
                errors++;
                $display("FAIL reset_flushed_write: got %h expected %h", wb_got(), wb_exp());
            end
        end
    endtask

    task automatic test_format();
        idle();
        drive_ld(1, 5, 3'b000, 2'd3, 32'h80FF_7F01);
        tick();
        checks++;
        if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL format_lb: got en=%b addr=%0d data=%h, expected 1 5 ffffff80", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        drive_ld(1, 5, 3'b100, 2'd3, 32'h80FF_7F01);
        tick();
        checks++;
        if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL format_lbu: got en=%b addr=%0d data=%h, expected 1 5 00000080", bus.wb_enable, bus.wb_addr, bus.wb_data);
        end
        for (int i = 0; i < 24; i++) begin
            drive_ld(1, 5'($urandom_range(1, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
            tick();
            checks++;
            if (wb_got() !== wb_exp()) begin
                errors++;
                $display("FAIL format_rand: f3=%0d off=%0d raw=%h got %h expected %h",
                         bus.ld_funct3, bus.ld_addr_low, bus.ld_raw, wb_got(), wb_exp());
            end
        end
        idle();
        tick();
    endtask

    task automatic test_collision();
        idle();
        drive_alu(1, 3, 32'hC0DE);
        drive_ld(1, 4, 3'd2, 0, 32'h1234);
        tick();
        idle();
        bus.query_rs1 = 4;
        #1;
        checks++;
        if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd3 || bus.stall_rs1 !== 1'b1 || bus.stall_rs1 !== m_stall(4)) begin
            errors++;
            $display("FAIL collision_c1: got en=%b addr=%0d stall=%b, expected 1 3 1", bus.wb_enable, bus.wb_addr, bus.stall_rs1);
        end
        tick();
        checks++;
        if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd4 || bus.wb_data !== 32'h1234 || bus.stall_rs1 !== 1'b0) begin
            errors++;
            $display("FAIL collision_c2: got en=%b addr=%0d data=%h stall=%b, expected 1 4 00001234 0",
                     bus.wb_enable, bus.wb_addr, bus.wb_data, bus.stall_rs1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        logic [4:0] got[$];
        logic [4:0] exp_addr [6] = '{5'd1, 5'd2, 5'd3, 5'd10, 5'd11, 5'd12};
        idle();
        for (int c = 0; c < 9; c++) begin
            drive_alu(c < 3, 5'(1 + c), $urandom);
            if (k < 3) drive_ld(1, 5'(10 + k), 3'd2, 0, $urandom);
            else drive_ld(0, 0, 0, 0, 0);
            #1;
            if (c == 2) begin
                checks++;
                if (bus.ld_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready: got %b expected 0 with two loads buffered", bus.ld_ready);
                end
            end
            tick();
            if (m_acc) k++;
            checks++;
            if (wb_got() !== wb_exp()) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", c, wb_got(), wb_exp());
            end
            if (bus.wb_enable) got.push_back(bus.wb_addr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, (i < got.size()) ? got[i] : 5'd0, exp_addr[i]);
            end
        end
        idle();
    endtask

    task automatic test_waw();
        idle();
        drive_alu(1, 2, 32'h55);
        drive_ld(1, 7, 3'd2, 0, 32'h777);
        tick();
        checks++;
        if (bus.buf_count !== 2'd1) begin
            errors++;
            $display("FAIL waw_buffered: got cnt=%0d expected 1", bus.buf_count);
        end
        idle();
        drive_alu(1, 7, 32'hAA);
        tick();
        checks++;
        if (bus.buf_count !== 2'd0 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'hAA || wb_got() !== wb_exp()) begin
            errors++;
            $display("FAIL waw_alu: got cnt=%0d addr=%0d data=%h expected 0 7 000000aa", bus.buf_count, bus.wb_addr, bus.wb_data);
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.wb_enable !== 1'b0) begin
                errors++;
                $display("FAIL waw_stale_write: got en=%b addr=%0d data=%h expected en=0", bus.wb_enable, bus.wb_addr, bus.wb_data);
            end
        end
    endtask

    task automatic test_x0();
        idle();
        drive_alu(1, 0, 32'hDEAD);
        drive_ld(1, 0, 3'd2, 0, 32'hBEEF);
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b expected 1", bus.ld_ready);
        end
        tick();
        checks++;
        if (bus.wb_enable !== 1'b0 || bus.buf_count !== 2'd0 || m_acc !== 1'b1) begin
            errors++;
            $display("FAIL x0_write: got en=%b cnt=%0d expected en=0 cnt=0", bus.wb_enable, bus.buf_count);
        end
        idle();
        tick();
        checks++;
        if (bus.wb_enable !== 1'b0 || bus.buf_count !== 2'd0) begin
            errors++;
            $display("FAIL x0_after: got en=%b cnt=%0d expected 0 0", bus.wb_enable, bus.buf_count);
        end
    endtask

    task automatic test_random();
        logic pend = 0;
        idle();
        for (int c = 0; c < 500; c++) begin
            sync_reset = ($urandom_range(0, 99) == 0);
            drive_alu($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom);
            if (sync_reset) pend = 0;
            else if (!pend && $urandom_range(0, 99) < 65) begin
                pend = 1;
                drive_ld(1, 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
            end
            bus.ld_valid = pend;
            bus.query_rs1 = 5'($urandom_range(0, 7));
            bus.query_rs2 = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if ({bus.ld_ready, bus.stall_rs1, bus.stall_rs2} !==
                {(mq.size() < DEPTH), m_stall(bus.query_rs1), m_stall(bus.query_rs2)}) begin
                errors++;
                $display("FAIL rand_comb cycle %0d: got ready/s1/s2=%b%b%b expected %b%b%b", c,
                         bus.ld_ready, bus.stall_rs1, bus.stall_rs2,
                         (mq.size() < DEPTH), m_stall(bus.query_rs1), m_stall(bus.query_rs2));
            end
            tick();
            if (m_acc) pend = 0;
            checks++;
            if (wb_got() !== wb_exp()) begin
                errors++;
                $display("FAIL rand_wb cycle %0d: got %h expected %h", c, wb_got(), wb_exp());
            end
        end
        sync_reset = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_format();
        test_collision();
        test_back_to_back();
        test_waw();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
